// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, reads the synchronous program ROM and
// hands {instruction, PC} to next-PC/decode over a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   run               fetch enable, sampled only while idle
//   rom_en, rom_addr  ROM read strobe and address (address = PC)
//   rom_data          ROM read data, valid the cycle after rom_en
//   instr_out, pc_out fetched instruction and its address
//   instr_valid       instr_out/pc_out valid, held until accepted
//   instr_ready       downstream accepts this cycle
//   next_pc           next fetch address, loaded on handshake
//   halted            halt opcode retired, fetching stopped
//   fetch_count       retired-instruction count (wraps)
module instr_fetch_unit #(
    parameter int                INSTR_W  = 8,
    parameter int                PC_W     = 4,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'b1111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               rom_en,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic [PC_W-1:0]    next_pc,
    output logic               halted,
    output logic [7:0]         fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_HALT
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [PC_W-1:0]      pc_q;
    logic [INSTR_W-1:0]   instr_q;
    logic [7:0]           count_q;
    logic                 handshake;
    logic                 is_halt;

    assign handshake = (state_q == S_PRESENT) && instr_ready;
    assign is_halt   = (instr_q[6:3] == HALT_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rom_en      = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                rom_en  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                instr_valid = 1'b1;
                if (instr_ready) state_d = is_halt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ROM data is captured only in WAIT, so a read left pending by a
    // reset lands while idle and is never latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            if (state_q == S_WAIT) instr_q <= rom_data;
            if (handshake) begin
                pc_q    <= next_pc;
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign rom_addr    = pc_q;
    assign pc_out      = pc_q;
    assign instr_out   = instr_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROM model, scoreboard of expected
// {instr, pc} popped at each handshake, plus per-scenario checks.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       rom_en;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] instr_out;
    logic [3:0] pc_out;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] next_pc;
    logic       halted;
    logic [7:0] fetch_count;

    int tests = 0;
    int fails = 0;

    logic [7:0]  rom [16];
    logic [11:0] sb_q [$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .rom_en(rom_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .instr_out(instr_out),
        .pc_out(pc_out),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .next_pc(next_pc),
        .halted(halted),
        .fetch_count(fetch_count)
    );

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    // Scoreboard: each handshake pops the oldest expectation.
    always @(negedge clk) begin
        logic [11:0] exp;
        if (instr_valid && instr_ready && !rst) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_empty: got %h/%h, required none",
                         instr_out, pc_out);
            end else begin
                exp = sb_q.pop_front();
                if ({instr_out, pc_out} !== exp) begin
                    fails++;
                    $display("FAIL sb_data: got %h/%h, required %h/%h",
                             instr_out, pc_out, exp[11:4], exp[3:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        instr_ready = 1'b0;
        next_pc = 4'h0;
        tick();
        tick();
        tests++;
        if ({rom_en, instr_valid, halted} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctl: got %b, required 000",
                     {rom_en, instr_valid, halted});
        end
        tests++;
        if ({fetch_count, instr_out, rom_addr} !== 20'h0) begin
            fails++;
            $display("FAIL reset_regs: got %h/%h/%h, required 0/0/0",
                     fetch_count, instr_out, rom_addr);
        end
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_first_fetch();
        run = 1'b1;
        instr_ready = 1'b1;
        next_pc = 4'h1;
        sb_q.push_back({rom[0], 4'h0});
        tick();
        run = 1'b0;
        tests++;
        if ({rom_en, rom_addr, instr_valid} !== {1'b1, 4'h0, 1'b0}) begin
            fails++;
            $display("FAIL first_fetch: got en=%b a=%h v=%b, required 1 0 0",
                     rom_en, rom_addr, instr_valid);
        end
        tick();
        tests++;
        if ({rom_en, instr_valid} !== 2'b00) begin
            fails++;
            $display("FAIL first_wait: got %b, required 00",
                     {rom_en, instr_valid});
        end
        tick();
        tests++;
        if ({instr_valid, instr_out, pc_out} !== {1'b1, 8'h28, 4'h0}) begin
            fails++;
            $display("FAIL first_valid: got %b %h %h, required 1 28 0",
                     instr_valid, instr_out, pc_out);
        end
        sb_q.push_back({rom[1], 4'h1});
        tick();
        tests++;
        if ({rom_en, rom_addr, fetch_count} !== {1'b1, 4'h1, 8'd1}) begin
            fails++;
            $display("FAIL next_addr: got en=%b a=%h c=%0d, required 1 1 1",
                     rom_en, rom_addr, fetch_count);
        end
        instr_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({instr_valid, instr_out, pc_out, rom_en, rom_addr} !==
                {1'b1, rom[1], 4'h1, 1'b0, 4'h1}) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b i=%h p=%h en=%b a=%h",
                         i, instr_valid, instr_out, pc_out, rom_en, rom_addr);
            end
        end
        instr_ready = 1'b1;
        next_pc = 4'hF;
        sb_q.push_back({rom[15], 4'hF});
        tick();
        tests++;
        if ({rom_en, rom_addr, fetch_count} !== {1'b1, 4'hF, 8'd2}) begin
            fails++;
            $display("FAIL bp_release: got en=%b a=%h c=%0d, required 1 f 2",
                     rom_en, rom_addr, fetch_count);
        end
    endtask

    task automatic test_wrap();
        next_pc = 4'h0;
        tick();
        tick();
        tests++;
        if ({instr_valid, pc_out} !== {1'b1, 4'hF}) begin
            fails++;
            $display("FAIL wrap_pc: got v=%b p=%h, required 1 f",
                     instr_valid, pc_out);
        end
        sb_q.push_back({rom[0], 4'h0});
        tick();
        tests++;
        if ({rom_en, rom_addr, fetch_count} !== {1'b1, 4'h0, 8'd3}) begin
            fails++;
            $display("FAIL wrap_addr: got en=%b a=%h c=%0d, required 1 0 3",
                     rom_en, rom_addr, fetch_count);
        end
        next_pc = 4'h2;
        sb_q.push_back({rom[2], 4'h2});
        tick();
        tick();
        tick();
    endtask

    task automatic test_halt();
        tick();
        tick();
        tests++;
        if ({instr_valid, instr_out} !== {1'b1, 8'h78}) begin
            fails++;
            $display("FAIL halt_instr: got v=%b i=%h, required 1 78",
                     instr_valid, instr_out);
        end
        tick();
        tests++;
        if ({halted, fetch_count} !== {1'b1, 8'd5}) begin
            fails++;
            $display("FAIL halt_enter: got h=%b c=%0d, required 1 5",
                     halted, fetch_count);
        end
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if ({rom_en, instr_valid, halted} !== 3'b001) begin
                fails++;
                $display("FAIL halt_hold%0d: got %b, required 001",
                         i, {rom_en, instr_valid, halted});
            end
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        test_reset();
        run = 1'b1;
        instr_ready = 1'b1;
        next_pc = 4'h5;
        sb_q.push_back({rom[0], 4'h0});
        tick();
        run = 1'b0;
        tick();
        tick();
        tick();
        instr_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({instr_valid, rom_en, rom_addr, fetch_count} !== 14'h0) begin
            fails++;
            $display("FAIL rst_wait: got v=%b en=%b a=%h c=%0d, required 0",
                     instr_valid, rom_en, rom_addr, fetch_count);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if ({instr_valid, instr_out} !== 9'h0) begin
                fails++;
                $display("FAIL rst_stale%0d: got v=%b i=%h, required 0 00",
                         i, instr_valid, instr_out);
            end
        end
    endtask

    task automatic test_count_wrap();
        int wt;
        test_reset();
        run = 1'b1;
        instr_ready = 1'b1;
        next_pc = 4'h1;
        sb_q.push_back({rom[0], 4'h0});
        for (int k = 0; k < 256; k++) begin
            wt = 0;
            while (!instr_valid && wt < 10) begin
                tick();
                run = 1'b0;
                wt++;
            end
            if (!instr_valid) begin
                tests++;
                fails++;
                $display("FAIL cnt_timeout: handshake %0d, got no valid", k);
                break;
            end
            sb_q.push_back({rom[1], 4'h1});
            tick();
            if (k == 254) begin
                tests++;
                if (fetch_count !== 8'd255) begin
                    fails++;
                    $display("FAIL cnt_255: got %0d, required 255",
                             fetch_count);
                end
            end
        end
        instr_ready = 1'b0;
        tests++;
        if (fetch_count !== 8'd0) begin
            fails++;
            $display("FAIL cnt_wrap: got %0d, required 0", fetch_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = {i[3:0], 4'h3};
        rom[0] = 8'h28;
        rom[2] = 8'b0_1111_000;
        rom_data = 8'h00;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_wrap();
        test_halt();
        test_reset_mid_wait();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
